// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NREG  = 4;
  localparam int unsigned DEF_NREQ  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_AW = addr_width(DEF_NREG);

endpackage

// File: rtl/reg_write_arbiter_bank.sv
// Bank of NREG enable-gated registers with async active-low clear and flat read bus.
module reg_bank
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREG  = DEF_NREG
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREG-1:0]       en,
  input  logic [WIDTH-1:0]      d,
  output logic [NREG*WIDTH-1:0] regs_q
);

  logic [WIDTH-1:0] q [NREG];

  for (genvar j = 0; j < NREG; j++) begin : g_reg
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        q[j] <= '0;
      end else if (en[j]) begin
        q[j] <= d;
      end
    end

    assign regs_q[j*WIDTH +: WIDTH] = q[j];
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter: one grant per IDLE edge, one-cycle Moore WRITE
// that drives the bank enable and acknowledges the captured requester.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned NREQ  = DEF_NREQ,
  localparam int unsigned AW   = addr_width(NREG),
  localparam int unsigned IDW  = addr_width(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [NREG*WIDTH-1:0] regs_q
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   hold_id, hold_id_nxt;
  logic [AW-1:0]    hold_addr, hold_addr_nxt;
  logic [WIDTH-1:0] hold_data, hold_data_nxt;

  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic [NREG-1:0]  bank_en;

  function automatic logic [IDW-1:0] wrap_idx(input int unsigned v);
    return IDW'(v % NREQ);
  endfunction

  // First set request scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!win_vld && req[wrap_idx(int'(ptr) + k)]) begin
        win_vld = 1'b1;
        win_id  = wrap_idx(int'(ptr) + k);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_addr = addr[i*AW +: AW];
        win_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_id   <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_id   <= hold_id_nxt;
      hold_addr <= hold_addr_nxt;
      hold_data <= hold_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_id_nxt   = hold_id;
    hold_addr_nxt = hold_addr;
    hold_data_nxt = hold_data;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          hold_id_nxt   = win_id;
          hold_addr_nxt = win_addr;
          hold_data_nxt = win_data;
          ptr_nxt       = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
          state_nxt     = WRITE;
        end
      end
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; an out-of-range address enables nothing.
  always_comb begin
    busy    = (state == WRITE);
    ack     = '0;
    bank_en = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ack[i] = busy && (hold_id == IDW'(i));
    end
    for (int unsigned j = 0; j < NREG; j++) begin
      bank_en[j] = busy && (hold_addr == AW'(j));
    end
  end

  reg_bank #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_bank (
    .CLK    (CLK),
    .RST    (RST),
    .en     (bank_en),
    .d      (hold_data),
    .regs_q (regs_q)
  );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected grants queued at drive time,
// popped and compared whenever the DUT acknowledges.
module tb_reg_write_arbiter;

  localparam int W  = 4;
  localparam int NR = 4;
  localparam int NQ = 4;
  localparam int AW = 2;

  logic            CLK;
  logic            RST;
  logic [NQ-1:0]   req;
  logic [NQ*AW-1:0] addr;
  logic [NQ*W-1:0] wdata;
  logic [NQ-1:0]   ack;
  logic            busy;
  logic [NR*W-1:0] regs_q;

  reg_write_arbiter #(
    .WIDTH (W),
    .NREG  (NR),
    .NREQ  (NQ)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .busy   (busy),
    .regs_q (regs_q)
  );

  typedef struct {
    int id;
    int a;
    int d;
  } exp_t;

  exp_t            sb[$];
  int              ack_log[$];
  int              cyc = 0;
  int              raise_cyc[NQ];
  logic [NR*W-1:0] shadow;
  int              n_checks = 0;
  int              n_fail = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input int a, input int d);
    addr[i*AW +: AW] = AW'(a);
    wdata[i*W +: W]  = W'(d);
    req[i]           = 1'b1;
    raise_cyc[i]     = cyc;
  endtask

  task automatic expect_wr(input int i, input int a, input int d);
    exp_t e;
    e.id = i;
    e.a  = a;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_regs", 32'(regs_q), 32'd0);
    req    = '0;
    shadow = '0;
    sb.delete();
    @(posedge CLK);
    #2 RST = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0 && req == '0) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
    if (!done) begin
      sb.delete();
      req = '0;
    end
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_ack(input int i, input int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge CLK);
      #1;
      if (ack[i]) found = 1'b1;
    end
    check_eq("wait_ack", 32'(found), 32'd1);
  endtask

  // Monitor: register bank must track the shadow copy; every ack pops one expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        check_eq("regs_q", 32'(regs_q), 32'(shadow));
        if (ack == '0) begin
          check_eq("busy_idle", 32'(busy), 32'd0);
        end else if (sb.size() == 0) begin
          check_eq("spurious_ack", 32'(ack), 32'd0);
          req = req & ~ack;
        end else begin
          e = sb.pop_front();
          check_eq("ack_id", 32'(ack), 32'd1 << e.id);
          check_eq("busy_write", 32'(busy), 32'd1);
          check_eq("wait_le8", 32'((cyc - raise_cyc[e.id]) <= 8), 32'd1);
          ack_log.push_back(cyc);
          shadow[e.a*W +: W] = W'(e.d);
          req = req & ~ack;
        end
      end
    end
  end

  initial begin
    #200000;
    check_eq("watchdog", 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST    = 1'b0;
    req    = '0;
    addr   = '0;
    wdata  = '0;
    shadow = '0;
    do_reset();

    // Single request after reset
    @(negedge CLK);
    drive(0, 2, 'hA);
    expect_wr(0, 2, 'hA);
    @(negedge CLK);
    #1;
    check_eq("t1_ack", 32'(ack), 32'd1);
    @(negedge CLK);
    #1;
    check_eq("t1_ack_once", 32'(ack), 32'd0);
    drain("t1_drain", 10);
    check_eq("t1_regs", 32'(regs_q), 32'h0A00);

    // All four request together from ptr=0
    do_reset();
    @(negedge CLK);
    ack_log.delete();
    for (int i = 0; i < NQ; i++) begin
      drive(i, 3 - i, i + 5);
      expect_wr(i, 3 - i, i + 5);
    end
    drain("t2_drain", 20);
    check_eq("t2_nacks", 32'(ack_log.size()), 32'd4);
    for (int k = 1; k < ack_log.size(); k++)
      check_eq("t2_spacing", 32'(ack_log[k] - ack_log[k-1]), 32'd2);
    check_eq("t2_regs", 32'(regs_q), 32'h5678);

    // ptr must have wrapped to 0: requester 0 beats requester 3
    @(negedge CLK);
    drive(3, 0, 1);
    drive(0, 0, 2);
    expect_wr(0, 0, 2);
    expect_wr(3, 0, 1);
    drain("t2_ptr_drain", 10);
    check_eq("t2_ptr_regs", 32'(regs_q), 32'h5671);

    // Fairness: requester 1 re-raises continuously, requester 3 also waiting
    @(negedge CLK);
    drive(1, 1, 'h9);
    drive(3, 2, 'h4);
    expect_wr(1, 1, 'h9);
    expect_wr(3, 2, 'h4);
    for (int r = 0; r < 2; r++) begin
      wait_ack(1, 20);
      @(negedge CLK);
      drive(1, 1, 'hA + r);
      expect_wr(1, 1, 'hA + r);
    end
    drain("t3_drain", 20);
    check_eq("t3_regs", 32'(regs_q), 32'h54B1);

    // Inputs change and req drops during WRITE; captured values still commit
    @(negedge CLK);
    drive(0, 0, 'h5);
    expect_wr(0, 0, 'h5);
    @(negedge CLK);
    #1;
    check_eq("t4_ack", 32'(ack), 32'd1);
    wdata[W-1:0] = 4'hF;
    addr[AW-1:0] = 2'd3;
    req[0]       = 1'b0;
    drain("t4_drain", 10);
    check_eq("t4_regs", 32'(regs_q), 32'h54B5);

    // Same-address conflict, last commit wins
    do_reset();
    @(negedge CLK);
    drive(0, 1, 'h3);
    drive(2, 1, 'hC);
    expect_wr(0, 1, 'h3);
    expect_wr(2, 1, 'hC);
    drain("t5_drain", 10);
    check_eq("t5_regs", 32'(regs_q), 32'h00C0);

    // Reset during the ack cycle
    @(negedge CLK);
    drive(2, 2, 'h7);
    expect_wr(2, 2, 'h7);
    @(negedge CLK);
    #1;
    check_eq("t6_ack", 32'(ack), 32'd4);
    RST = 1'b0;
    #1;
    check_eq("t6_rst_ack", 32'(ack), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_regs", 32'(regs_q), 32'd0);
    req    = '0;
    shadow = '0;
    sb.delete();
    @(posedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    drive(1, 0, 'h6);
    drive(3, 3, 'hD);
    expect_wr(1, 0, 'h6);
    expect_wr(3, 3, 'hD);
    drain("t6_drain", 10);
    check_eq("t6_regs", 32'(regs_q), 32'hD006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
